alu_seg_scan_driver: RTL and testbench

//  Downstream display stage of the 4-bit ALU. Captures the ALU's BCD result (hundreds/tens/ones)
//  and its status flags (error, carry_out, overflow). Drives a 4-digit, common-anode,

---
 rtl/alu_seg_scan_driver_pkg.sv | 39 +++
 rtl/alu_seg_scan_driver_if.sv | 19 +
 rtl/alu_seg_scan_driver_bcd_to_seg.sv | 41 ++++
 rtl/alu_seg_scan_driver.sv | 195 +++++++++++++++++++
 tb/tb_alu_seg_scan_driver.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/alu_seg_scan_driver_pkg.sv
// alu_disp_pkg: shared definitions for the ALU 7-segment scan driver.
//  - Segment codes are {g,f,e,d,c,b,a}, active-low (0 = segment lit).
//  - scan_state_t: per-slot scan phase (anodes off, then digit lit).
//  - digit_idx_t : which of the four digits is being scanned (3 = status).
//  - alu_snap_t  : shadow copy of the ALU result captured on upd.
package alu_disp_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_E    = 7'h06;
  localparam logic [6:0] SEG_C    = 7'h46;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } scan_state_t;

  typedef logic [1:0] digit_idx_t;

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    logic       error;
    logic       carry_out;
    logic       overflow;
  } alu_snap_t;

endpackage

// File: rtl/alu_seg_scan_driver_if.sv
// alu_seg_scan_driver_if: ALU result bus feeding the display driver.
//  h, t, o    : BCD hundreds/tens/ones digits (bit3 = MSB)
//  error      : invalid-opcode flag
//  carry_out  : carry/borrow flag
//  overflow   : overflow flag
//  upd        : capture strobe, snapshot all of the above
//  master = ALU side (drives), slave = display driver (samples).
interface alu_seg_scan_driver_if;
  logic [3:0] h;
  logic [3:0] t;
  logic [3:0] o;
  logic       error;
  logic       carry_out;
  logic       overflow;
  logic       upd;

  modport master (output h, t, o, error, carry_out, overflow, upd);
  modport slave  (input  h, t, o, error, carry_out, overflow, upd);
endinterface

// File: rtl/alu_seg_scan_driver_bcd_to_seg.sv
// bcd_to_seg: combinational digit decoder for the scan driver.
//  nibble     in  4  digit value; 0-9 decode to numerals, 4'hE -> 'E', 4'hC -> 'C'
//  blank      in  1  show nothing (leading-zero / empty status digit)
//  force_dash in  1  show '-' (error or out-of-range digit); overrides blank
//  seg        out 7  {g,f,e,d,c,b,a}, active-low
module bcd_to_seg
  import alu_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       force_dash,
  output logic [6:0] seg
);

  // Priority: dash, then blank, then glyph lookup.
  always_comb begin
    seg = SEG_OFF;
    if (force_dash) begin
      seg = SEG_DASH;
    end else if (blank) begin
      seg = SEG_OFF;
    end else begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        4'hC:    seg = SEG_C;
        4'hE:    seg = SEG_E;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/alu_seg_scan_driver.sv
// alu_seg_scan_driver: 4-digit common-anode multiplexed 7-segment driver for the
// 4-bit ALU. Digit3 shows status (E / C / blank, dp = overflow), digits2..0 show
// the captured BCD value with leading-zero blanking.
//  clk    in   1  system clock
//  rst_n  in   1  synchronous active-low reset
//  alu    slave   ALU result bus (h, t, o, error, carry_out, overflow, upd)
//  seg    out  7  {g,f,e,d,c,b,a}, active-low, registered
//  dp     out  1  decimal point, active-low, registered
//  an     out  4  anodes, active-low, an[3] = status digit, registered
// Optional build macro ERR_BLINK_EN: blink the whole display while error is
// captured, toggling every BLINK_FRAMES frames. Without it the error display
// is steady.
module alu_seg_scan_driver
  import alu_disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_seg_scan_driver_if.slave alu,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic [3:0]           an
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_CYC - 1);

  alu_snap_t        snap_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  scan_state_t      state_r;
  scan_state_t      state_nxt_s;
  digit_idx_t       idx_r;
  digit_idx_t       idx_nxt_s;
  logic             last_s;
  logic [3:0]       nib_s;
  logic             blank_s;
  logic             dash_s;
  logic             dp_s;
  logic [3:0]       an_on_s;
  logic [6:0]       seg_dec_s;
  logic             blink_mask_s;
  logic [6:0]       seg_r;
  logic             dp_r;
  logic [3:0]       an_r;

  assign seg = seg_r;
  assign dp  = dp_r;
  assign an  = an_r;

  // Shadow capture: display only follows the ALU on an explicit upd strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_r <= '0;
    end else if (alu.upd) begin
      snap_r <= '{h: alu.h, t: alu.t, o: alu.o, error: alu.error,
                  carry_out: alu.carry_out, overflow: alu.overflow};
    end else begin
      snap_r <= snap_r;
    end
  end

  // Next prescaler count, scan state and digit index.
  always_comb begin
    last_s      = (cnt_r == CNT_LAST);
    cnt_nxt_s   = last_s ? '0 : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    case (state_r)
      S_BLANK: begin
        if (cnt_r == CNT_BLANK_END) begin
          state_nxt_s = S_ON;
        end else begin
          state_nxt_s = S_BLANK;
        end
      end
      S_ON: begin
        if (last_s) begin
          state_nxt_s = S_BLANK;
          idx_nxt_s   = idx_r + 2'd1;
        end else begin
          state_nxt_s = S_ON;
        end
      end
      default: state_nxt_s = S_BLANK;
    endcase
  end

  // Digit mux on the upcoming index so seg and an change on the same edge.
  always_comb begin
    nib_s   = snap_r.o;
    blank_s = 1'b0;
    dash_s  = 1'b0;
    case (idx_nxt_s)
      2'd0: begin
        nib_s  = snap_r.o;
        dash_s = snap_r.error || (snap_r.o > 4'd9);
      end
      2'd1: begin
        nib_s   = snap_r.t;
        dash_s  = snap_r.error || (snap_r.t > 4'd9);
        blank_s = (snap_r.h == 4'd0) && (snap_r.t == 4'd0);
      end
      2'd2: begin
        nib_s   = snap_r.h;
        dash_s  = snap_r.error || (snap_r.h > 4'd9);
        blank_s = (snap_r.h == 4'd0);
      end
      2'd3: begin
        nib_s   = snap_r.error ? 4'hE : 4'hC;
        blank_s = !snap_r.error && !snap_r.carry_out;
      end
      default: begin
        blank_s = 1'b1;
      end
    endcase
    dp_s    = !((idx_nxt_s == 2'd3) && snap_r.overflow);
    an_on_s = ~(4'b0001 << idx_nxt_s);
  end

  bcd_to_seg u_bcd_to_seg (
    .nibble     (nib_s),
    .blank      (blank_s),
    .force_dash (dash_s),
    .seg        (seg_dec_s)
  );

`ifdef ERR_BLINK_EN
  localparam int FRM_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [FRM_W-1:0] frame_cnt_r;
  logic             blink_off_r;
  logic             wrap_s;

  // A frame completes when the status digit slot ends (idx 3 -> 0).
  assign wrap_s = (state_r == S_ON) && last_s && (idx_r == 2'd3);

  // Blink phase: frozen "on" while no error is captured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_r <= '0;
      blink_off_r <= 1'b0;
    end else if (!snap_r.error) begin
      frame_cnt_r <= '0;
      blink_off_r <= 1'b0;
    end else if (wrap_s) begin
      if (frame_cnt_r == FRM_LAST) begin
        frame_cnt_r <= '0;
        blink_off_r <= !blink_off_r;
      end else begin
        frame_cnt_r <= frame_cnt_r + {{(FRM_W-1){1'b0}}, 1'b1};
        blink_off_r <= blink_off_r;
      end
    end else begin
      frame_cnt_r <= frame_cnt_r;
      blink_off_r <= blink_off_r;
    end
  end

  assign blink_mask_s = snap_r.error && blink_off_r;
`else
  assign blink_mask_s = 1'b0;
`endif

  // Scan FSM with registered display outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      state_r <= S_BLANK;
      idx_r   <= 2'd0;
      seg_r   <= SEG_OFF;
      dp_r    <= 1'b1;
      an_r    <= 4'hF;
    end else begin
      cnt_r   <= cnt_nxt_s;
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      if ((state_nxt_s == S_ON) && !blink_mask_s) begin
        seg_r <= seg_dec_s;
        dp_r  <= dp_s;
        an_r  <= an_on_s;
      end else begin
        seg_r <= SEG_OFF;
        dp_r  <= 1'b1;
        an_r  <= 4'hF;
      end
    end
  end

endmodule

// File: tb/tb_alu_seg_scan_driver.sv
// Self-checking bench for alu_seg_scan_driver (REFRESH_DIV=8, BLANK_CYC=2,
// BLINK_FRAMES=2). The reference model tracks elapsed cycles since reset and
// the captured ALU value, and derives the expected display from the slot
// arithmetic and the digit rules.
module tb_alu_seg_scan_driver;

  localparam int RDIV   = 8;
  localparam int BLANK  = 2;
  localparam int BFRM   = 2;
  localparam int FRAME  = 4 * RDIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  alu_seg_scan_driver_if bus ();

  alu_seg_scan_driver #(
    .REFRESH_DIV  (RDIV),
    .BLANK_CYC    (BLANK),
    .BLINK_FRAMES (BFRM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .alu   (bus),
    .seg   (seg),
    .dp    (dp),
    .an    (an)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state
  int         k      = 0;
  int         frames = 0;
  logic [3:0] m_h = 4'd0, m_t = 4'd0, m_o = 4'd0;
  logic       m_e = 1'b0, m_c = 1'b0, m_v = 1'b0;
  logic [6:0] num_tab [10];

  // Current bus drive values
  logic [3:0] c_h = 4'd0, c_t = 4'd0, c_o = 4'd0;
  logic       c_e = 1'b0, c_c = 1'b0, c_v = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, k, obs, exp);
    end else begin
      passed++;
    end
  endtask

  function automatic logic [6:0] exp_digit(input int idx);
    logic [3:0] n;
    if (idx == 3) return m_e ? 7'h06 : (m_c ? 7'h46 : 7'h7F);
    if (m_e) return 7'h3F;
    n = (idx == 0) ? m_o : ((idx == 1) ? m_t : m_h);
    if (n > 4'd9) return 7'h3F;
    if (idx == 2 && m_h == 4'd0) return 7'h7F;
    if (idx == 1 && m_h == 4'd0 && m_t == 4'd0) return 7'h7F;
    return num_tab[n];
  endfunction

  // One clock: drive, let the edge happen, predict, then compare.
  task automatic tick(input logic rn, input logic u);
    int         cnt;
    int         idx;
    logic       lit;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    rst_n        = rn;
    bus.upd      = u;
    bus.h        = c_h;
    bus.t        = c_t;
    bus.o        = c_o;
    bus.error    = c_e;
    bus.carry_out = c_c;
    bus.overflow = c_v;
    @(posedge clk);
    if (!rn) k = 0; else k++;
    cnt = k % RDIV;
    idx = (k / RDIV) % 4;
    lit = rn && (cnt >= BLANK);
`ifdef ERR_BLINK_EN
    if (m_e && (((frames / BFRM) % 2) == 1)) lit = 1'b0;
`endif
    an_e  = lit ? ~(4'b0001 << idx) : 4'hF;
    seg_e = lit ? exp_digit(idx) : 7'h7F;
    dp_e  = lit ? !(idx == 3 && m_v) : 1'b1;
    if (!rn) begin
      frames = 0;
      {m_h, m_t, m_o, m_e, m_c, m_v} = '0;
    end else begin
      if (!m_e) frames = 0;
      else if (k % FRAME == 0) frames++;
      if (u) begin
        m_h = c_h; m_t = c_t; m_o = c_o; m_e = c_e; m_c = c_c; m_v = c_v;
      end
    end
    #1;
    check_val("an", 32'(an), 32'(an_e));
    check_val("seg", 32'(seg), 32'(seg_e));
    check_val("dp", 32'(dp), 32'(dp_e));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
  endtask

  task automatic load(input logic [3:0] hh, tt, oo, input logic e, c, v);
    c_h = hh; c_t = tt; c_o = oo; c_e = e; c_c = c; c_v = v;
    tick(1'b1, 1'b1);
  endtask

  function automatic logic [3:0] rnd_nib();
    if ($urandom_range(0, 3) == 0) return 4'd0;
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    num_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Reset, then idle with zero shadow through more than one frame
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_val("reset_an", 32'(an), 32'hF);
    check_val("reset_seg", 32'(seg), 32'h7F);
    idle(40);

    // 105: tens zero shown, hundreds lit
    load(4'd1, 4'd0, 4'd5, 1'b0, 1'b0, 1'b0);
    idle(FRAME + 4);

    // 7 with carry and overflow: 'C' and dp on the status digit
    load(4'd0, 4'd0, 4'd7, 1'b0, 1'b1, 1'b1);
    idle(FRAME + 4);

    // Error display (and blink phases when enabled)
    load(4'd3, 4'd2, 4'd1, 1'b1, 1'b0, 1'b0);
    idle(6 * FRAME);

    // Out-of-range ones digit, then update during digit0's lit phase
    load(4'd0, 4'd4, 4'hC, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2 * FRAME && (k % FRAME) != 4; i++) idle(1);
    load(4'd9, 4'd8, 4'd6, 1'b0, 1'b0, 1'b0);
    idle(FRAME);

    // Reset in the middle of digit2's lit phase
    for (int i = 0; i < 2 * FRAME && (k % FRAME) != 2 * RDIV + 4; i++) idle(1);
    tick(1'b0, 1'b0);
    idle(FRAME);

    // Random traffic: bus wiggles every cycle, captured only on upd
    for (int i = 0; i < 1500; i++) begin
      c_h = rnd_nib();
      c_t = rnd_nib();
      c_o = rnd_nib();
      c_e = ($urandom_range(0, 5) == 0);
      c_c = 1'($urandom_range(0, 1));
      c_v = 1'($urandom_range(0, 1));
      tick(($urandom_range(0, 299) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
